// File: rtl/banco_registros_wb_pkg.sv
// rtl/banco_registros_wb_pkg.sv - shared widths and constants for the writeback register bank
package banco_registros_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/banco_registros_wb_marcador_cargas.sv
// rtl/banco_registros_wb_marcador_cargas.sv - load scoreboard: pending bits, outstanding count, busy lookup
import banco_registros_wb_pkg::*;

module marcador_cargas #(
  parameter int ADDR_W = banco_registros_wb_pkg::ADDR_W,
  parameter int NREGS  = banco_registros_wb_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setEn,
  input  logic [ADDR_W-1:0] setAddr,
  input  logic              clrEn,
  input  logic [ADDR_W-1:0] clrAddr,
  input  logic [ADDR_W-1:0] qAddr1,
  input  logic [ADDR_W-1:0] qAddr2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   ldCount
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pendNext;
  logic [ADDR_W:0]  countNext;
  logic             doSet;
  logic             doClr;

  // A new load to the same register supersedes the retiring one, so the set masks the clear.
  always_comb begin
    pendNext  = pend;
    countNext = ldCount;
    doSet     = setEn && (setAddr != ZERO_ADDR);
    doClr     = clrEn && (clrAddr != ZERO_ADDR) && !(doSet && (setAddr == clrAddr));
    if (doClr && pend[clrAddr]) begin
      pendNext[clrAddr] = 1'b0;
      countNext         = countNext - 1'b1;
    end
    if (doSet && !pend[setAddr]) begin
      pendNext[setAddr] = 1'b1;
      countNext         = countNext + 1'b1;
    end
    pendNext[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      ldCount <= '0;
    end else begin
      pend    <= pendNext;
      ldCount <= countNext;
    end
  end

  assign busy1 = pend[qAddr1];
  assign busy2 = pend[qAddr2];

endmodule

// File: rtl/banco_registros_wb.sv
// rtl/banco_registros_wb.sv - architectural register bank with write bypass and load-use stall
import banco_registros_wb_pkg::*;

module banco_registros_wb #(
  parameter int DATA_W = banco_registros_wb_pkg::DATA_W,
  parameter int ADDR_W = banco_registros_wb_pkg::ADDR_W,
  parameter int NREGS  = banco_registros_wb_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wEn,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              wIsLoad,
  input  logic [ADDR_W-1:0] rAddr1,
  input  logic [ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0] rData1,
  output logic [DATA_W-1:0] rData2,
  input  logic              ldIssue,
  input  logic [ADDR_W-1:0] ldAddr,
  output logic              stall,
  output logic [ADDR_W:0]   ldCount
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wValid;
  logic              ldRetire;
  logic              clr1;
  logic              clr2;
  logic              busy1;
  logic              busy2;

  assign wValid   = wEn && (wAddr != ZERO_ADDR);
  assign ldRetire = wValid && wIsLoad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wValid) begin
      regs[wAddr] <= wData;
    end
  end

  always_comb begin
    rData1 = regs[rAddr1];
    if (rAddr1 == ZERO_ADDR) begin
      rData1 = '0;
    end else if (wValid && (wAddr == rAddr1)) begin
      rData1 = wData;
    end
  end

  always_comb begin
    rData2 = regs[rAddr2];
    if (rAddr2 == ZERO_ADDR) begin
      rData2 = '0;
    end else if (wValid && (wAddr == rAddr2)) begin
      rData2 = wData;
    end
  end

  marcador_cargas #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) uMarcador (
    .clk     (clk),
    .rst_n   (rst_n),
    .setEn   (ldIssue),
    .setAddr (ldAddr),
    .clrEn   (ldRetire),
    .clrAddr (wAddr),
    .qAddr1  (rAddr1),
    .qAddr2  (rAddr2),
    .busy1   (busy1),
    .busy2   (busy2),
    .ldCount (ldCount)
  );

  // A load retiring this cycle already feeds the bypass, so its reader need not hold.
  assign clr1  = ldRetire && (wAddr == rAddr1);
  assign clr2  = ldRetire && (wAddr == rAddr2);
  assign stall = (busy1 && !clr1) || (busy2 && !clr2);

endmodule

// File: tb/tb_banco_registros_wb.sv
// tb/tb_banco_registros_wb.sv - self-checking bench for the writeback register bank
module tb_banco_registros_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wEn;
  logic [4:0]  wAddr;
  logic [31:0] wData;
  logic        wIsLoad;
  logic [4:0]  rAddr1;
  logic [4:0]  rAddr2;
  logic [31:0] rData1;
  logic [31:0] rData2;
  logic        ldIssue;
  logic [4:0]  ldAddr;
  logic        stall;
  logic [5:0]  ldCount;

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_STALL = 2;
  localparam int SEL_CNT = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } expT;

  expT         sbq [$];
  int          nChecks = 0;
  int          nErrors = 0;
  logic [31:0] mdl [32];

  banco_registros_wb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wEn     (wEn),
    .wAddr   (wAddr),
    .wData   (wData),
    .wIsLoad (wIsLoad),
    .rAddr1  (rAddr1),
    .rAddr2  (rAddr2),
    .rData1  (rData1),
    .rData2  (rData2),
    .ldIssue (ldIssue),
    .ldAddr  (ldAddr),
    .stall   (stall),
    .ldCount (ldCount)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expectVal(input string tag, input int sel, input logic [31:0] val);
    expT e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic drainChecks();
    expT         e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        SEL_RD1:   obs = rData1;
        SEL_RD2:   obs = rData2;
        SEL_STALL: obs = {31'b0, stall};
        default:   obs = {26'b0, ldCount};
      endcase
      checkVal(e.tag, obs, e.val);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wEn = 1'b0; wAddr = '0; wData = '0; wIsLoad = 1'b0;
    ldIssue = 1'b0; ldAddr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    rAddr1 = 5'd0;
    rAddr2 = 5'd0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    repeat (3) nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Reset state on every address
    for (int a = 0; a < 32; a++) begin
      rAddr1 = 5'(a);
      rAddr2 = 5'(31 - a);
      #1;
      expectVal($sformatf("rst_rd1_%0d", a), SEL_RD1, 32'h0);
      expectVal($sformatf("rst_rd2_%0d", a), SEL_RD2, 32'h0);
      expectVal($sformatf("rst_stall_%0d", a), SEL_STALL, 32'h0);
      expectVal($sformatf("rst_cnt_%0d", a), SEL_CNT, 32'h0);
      drainChecks();
    end
    nextCycle();

    // Bypass then committed value
    wEn = 1'b1; wAddr = 5'd5; wData = 32'hDEADBEEF; rAddr1 = 5'd5; rAddr2 = 5'd0;
    #1;
    expectVal("bypass_rd1", SEL_RD1, 32'hDEADBEEF);
    drainChecks();
    nextCycle();
    mdl[5] = 32'hDEADBEEF;
    idleInputs();
    #1;
    expectVal("commit_rd1", SEL_RD1, 32'hDEADBEEF);
    drainChecks();

    // Register zero ignores writes
    wEn = 1'b1; wAddr = 5'd0; wData = 32'hFFFFFFFF; rAddr1 = 5'd0;
    #1;
    expectVal("r0_during", SEL_RD1, 32'h0);
    drainChecks();
    nextCycle();
    idleInputs();
    #1;
    expectVal("r0_after", SEL_RD1, 32'h0);
    drainChecks();

    // Load issue, stall, retire with bypass
    ldIssue = 1'b1; ldAddr = 5'd7;
    nextCycle();
    idleInputs();
    rAddr1 = 5'd0; rAddr2 = 5'd7;
    #1;
    expectVal("ld7_cnt", SEL_CNT, 32'd1);
    expectVal("ld7_stall", SEL_STALL, 32'd1);
    drainChecks();
    wEn = 1'b1; wIsLoad = 1'b1; wAddr = 5'd7; wData = 32'h1234;
    #1;
    expectVal("ld7_retire_stall", SEL_STALL, 32'd0);
    expectVal("ld7_retire_rd2", SEL_RD2, 32'h1234);
    drainChecks();
    nextCycle();
    mdl[7] = 32'h1234;
    idleInputs();
    #1;
    expectVal("ld7_done_cnt", SEL_CNT, 32'd0);
    expectVal("ld7_done_stall", SEL_STALL, 32'd0);
    expectVal("ld7_done_rd2", SEL_RD2, 32'h1234);
    drainChecks();

    // Clear on a non-pending register has no effect
    wEn = 1'b1; wIsLoad = 1'b1; wAddr = 5'd12; wData = 32'hA5A5A5A5;
    nextCycle();
    mdl[12] = 32'hA5A5A5A5;
    idleInputs();
    #1;
    expectVal("clr_nonpend_cnt", SEL_CNT, 32'd0);
    drainChecks();

    // Set beats clear on the same register
    ldIssue = 1'b1; ldAddr = 5'd9;
    nextCycle();
    idleInputs();
    #1;
    expectVal("ld9_cnt", SEL_CNT, 32'd1);
    drainChecks();
    ldIssue = 1'b1; ldAddr = 5'd9; wEn = 1'b1; wIsLoad = 1'b1; wAddr = 5'd9; wData = 32'h55;
    nextCycle();
    mdl[9] = 32'h55;
    idleInputs();
    rAddr1 = 5'd9; rAddr2 = 5'd0;
    #1;
    expectVal("ld9_setwins_cnt", SEL_CNT, 32'd1);
    expectVal("ld9_setwins_stall", SEL_STALL, 32'd1);
    expectVal("ld9_setwins_rd1", SEL_RD1, 32'h55);
    drainChecks();
    wEn = 1'b1; wIsLoad = 1'b0; wAddr = 5'd9; wData = 32'h66;
    #1;
    expectVal("ld9_alu_stall", SEL_STALL, 32'd1);
    expectVal("ld9_alu_rd1", SEL_RD1, 32'h66);
    drainChecks();
    nextCycle();
    mdl[9] = 32'h66;
    idleInputs();
    #1;
    expectVal("ld9_alu_after_stall", SEL_STALL, 32'd1);
    expectVal("ld9_alu_after_cnt", SEL_CNT, 32'd1);
    drainChecks();
    wEn = 1'b1; wIsLoad = 1'b1; wAddr = 5'd9; wData = 32'h77;
    nextCycle();
    mdl[9] = 32'h77;
    idleInputs();
    #1;
    expectVal("ld9_retired_cnt", SEL_CNT, 32'd0);
    expectVal("ld9_retired_stall", SEL_STALL, 32'd0);
    drainChecks();

    // Random ALU writes, then full readback through both ports
    for (int i = 0; i < 40; i++) begin
      wEn = 1'b1; wIsLoad = 1'b0;
      wAddr = 5'($urandom_range(1, 31));
      wData = $urandom;
      nextCycle();
      mdl[wAddr] = wData;
    end
    idleInputs();
    for (int a = 0; a < 32; a++) begin
      rAddr1 = 5'(a);
      rAddr2 = 5'((a + 13) % 32);
      #1;
      expectVal($sformatf("rand_rd1_%0d", a), SEL_RD1, (a == 0) ? 32'h0 : mdl[a]);
      expectVal($sformatf("rand_rd2_%0d", a), SEL_RD2,
                (((a + 13) % 32) == 0) ? 32'h0 : mdl[(a + 13) % 32]);
      drainChecks();
    end

    // Three distinct loads (with a repeat and a zero target), then async reset
    nextCycle();
    ldIssue = 1'b1; ldAddr = 5'd3; nextCycle();
    ldAddr = 5'd4; nextCycle();
    ldAddr = 5'd6; nextCycle();
    ldAddr = 5'd3; nextCycle();
    ldAddr = 5'd0; nextCycle();
    idleInputs();
    rAddr1 = 5'd4; rAddr2 = 5'd5;
    #1;
    expectVal("ld346_cnt", SEL_CNT, 32'd3);
    expectVal("ld346_stall", SEL_STALL, 32'd1);
    drainChecks();
    #1;
    rst_n = 1'b0;
    #1;
    expectVal("async_rst_cnt", SEL_CNT, 32'd0);
    expectVal("async_rst_stall", SEL_STALL, 32'd0);
    expectVal("async_rst_rd2", SEL_RD2, 32'h0);
    drainChecks();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    rAddr1 = 5'd6; rAddr2 = 5'd3;
    #1;
    expectVal("post_rst_stall", SEL_STALL, 32'd0);
    expectVal("post_rst_cnt", SEL_CNT, 32'd0);
    drainChecks();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
